// File: rtl/traffic_light_seq.sv
// traffic_light_seq: UK lamp sequencer RED -> RED+AMBER -> GREEN -> AMBER with per-phase timers.
// Optional pedestrian request (shortens GREEN, drives walk) when TRAFFIC_PED_REQ_EN is defined.
module traffic_light_seq #(
  parameter int RED_CYC       = 8,
  parameter int REDAMB_CYC    = 2,
  parameter int GREEN_CYC     = 10,
  parameter int AMBER_CYC     = 3,
  parameter int GREEN_MIN_CYC = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
`ifdef TRAFFIC_PED_REQ_EN
  input  logic       ped_req,
  output logic       walk,
`endif
  output logic       red,
  output logic       amber,
  output logic       green,
  output logic [1:0] phase
);
  typedef enum logic [1:0] {S_RED, S_REDAMB, S_GREEN, S_AMBER} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic             r_red, r_amber, r_green;
  state_t           w_next;
  logic [CNT_W-1:0] w_load, w_elapsed;
  logic             w_pend, w_adv;
  always_comb begin
    w_next    = state_t'(r_state + 2'd1);
    w_load    = w_next == S_RED    ? CNT_W'(RED_CYC - 1) :
                w_next == S_REDAMB ? CNT_W'(REDAMB_CYC - 1) :
                w_next == S_GREEN  ? CNT_W'(GREEN_CYC - 1) : CNT_W'(AMBER_CYC - 1);
    w_elapsed = CNT_W'(GREEN_CYC - 1) - r_timer;
    // GREEN may end early once a pending request has seen the minimum green time
    w_adv     = r_timer == '0 ||
                (r_state == S_GREEN && w_pend && w_elapsed >= CNT_W'(GREEN_MIN_CYC - 1));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RED;
      r_timer <= CNT_W'(RED_CYC - 1);
      r_red   <= 1'b1;
      r_amber <= 1'b0;
      r_green <= 1'b0;
    end else if (enable) begin
      if (w_adv) begin
        r_state <= w_next;
        r_timer <= w_load;
        r_red   <= w_next == S_RED || w_next == S_REDAMB;
        r_amber <= w_next == S_REDAMB || w_next == S_AMBER;
        r_green <= w_next == S_GREEN;
      end else begin
        r_timer <= r_timer - 1'b1;
      end
    end
  end
`ifdef TRAFFIC_PED_REQ_EN
  logic r_pend, r_walk;
  assign w_pend = r_pend;
  assign walk   = r_walk;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 1'b0;
      r_walk <= 1'b0;
    end else begin
      r_pend <= ped_req || (r_pend && !(enable && w_adv && w_next == S_RED));
      if (enable && w_adv)
        r_walk <= w_next == S_RED && r_pend;
    end
  end
`else
  assign w_pend = 1'b0;
`endif
  assign phase = r_state;
  assign red   = r_red;
  assign amber = r_amber;
  assign green = r_green;
endmodule

// File: tb/tb_traffic_light_seq.sv
// tb_traffic_light_seq: table-driven and directed checks of traffic_light_seq.
// Ped-request sequences run only when TRAFFIC_PED_REQ_EN is defined.
module tb_traffic_light_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic ped_req = 1'b0;
  logic red_a, amber_a, green_a, walk_a;
  logic red_b, amber_b, green_b, walk_b;
  logic [1:0] phase_a, phase_b;
  int pass_cnt = 0;
  int tot_cnt = 0;

  always #5 clk = ~clk;

  traffic_light_seq #(.RED_CYC(4), .REDAMB_CYC(2), .GREEN_CYC(5), .AMBER_CYC(3),
                      .GREEN_MIN_CYC(2), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .enable(enable),
`ifdef TRAFFIC_PED_REQ_EN
    .ped_req(ped_req), .walk(walk_a),
`endif
    .red(red_a), .amber(amber_a), .green(green_a), .phase(phase_a));

  traffic_light_seq #(.RED_CYC(1), .REDAMB_CYC(1), .GREEN_CYC(1), .AMBER_CYC(1),
                      .GREEN_MIN_CYC(1), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .enable(enable),
`ifdef TRAFFIC_PED_REQ_EN
    .ped_req(1'b0), .walk(walk_b),
`endif
    .red(red_b), .amber(amber_b), .green(green_b), .phase(phase_b));

`ifndef TRAFFIC_PED_REQ_EN
  assign walk_a = 1'b0;
  assign walk_b = 1'b0;
`endif

  typedef struct {logic rst; logic en; logic [1:0] ph;} vec_t;
  vec_t tv[$];

  function automatic logic [2:0] lamps(input logic [1:0] p);
    return p == 2'd0 ? 3'b100 : p == 2'd1 ? 3'b110 : p == 2'd2 ? 3'b001 : 3'b010;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_a(input string name, input logic [1:0] ph);
    chk({name, " phase"}, {6'd0, phase_a}, {6'd0, ph});
    chk({name, " lamps"}, {5'd0, red_a, amber_a, green_a}, {5'd0, lamps(ph)});
  endtask

  task automatic do_reset();
    ped_req = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] exp6 [31] = '{0,0,0,0,1,1,2,2,2,2,3,3,3,0,0,0,0,1,1,2,2,2,2,2,3,3,3,0,0,0,0};
    logic [1:0] exp5 [15] = '{0,0,0,1,1,2,2,3,3,3,0,0,0,0,1};
    // full-period trace: R x4, RA x2, G x5, A x3, then wrap
    tv.push_back('{1'b1, 1'b1, 2'd0});
    for (int i = 1; i < 19; i++)
      tv.push_back('{1'b0, 1'b1, i % 14 < 4 ? 2'd0 : i % 14 < 6 ? 2'd1 : i % 14 < 11 ? 2'd2 : 2'd3});
    // freeze for 6 edges at GREEN cycle 2; GREEN still totals 5 enabled cycles
    tv.push_back('{1'b1, 1'b1, 2'd0});
    for (int i = 1; i < 6; i++) tv.push_back('{1'b0, 1'b1, i < 4 ? 2'd0 : 2'd1});
    tv.push_back('{1'b0, 1'b1, 2'd2});
    for (int i = 0; i < 6; i++) tv.push_back('{1'b0, 1'b0, 2'd2});
    for (int i = 0; i < 4; i++) tv.push_back('{1'b0, 1'b1, 2'd2});
    for (int i = 0; i < 3; i++) tv.push_back('{1'b0, 1'b1, 2'd3});
    tv.push_back('{1'b0, 1'b1, 2'd0});

    @(negedge clk);
    chk("reset lamps", {5'd0, red_a, amber_a, green_a}, 8'h04);
    chk("reset walk", {7'd0, walk_a}, 8'h00);
    foreach (tv[i]) begin
      if (tv[i].rst) do_reset();
      enable = tv[i].en;
      chk_a($sformatf("vec%0d", i), tv[i].ph);
      step();
    end

    // asynchronous reset mid-AMBER
    do_reset();
    enable = 1'b1;
    repeat (11) step();
    chk_a("pre-rst amber", 2'd3);
    #2 rst = 1'b1;
    #1 chk_a("async rst", 2'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_a($sformatf("post-rst%0d", i), i < 4 ? 2'd0 : 2'd1);
      step();
    end

    // single-cycle phases
    do_reset();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("cyc1 phase%0d", i), {6'd0, phase_b}, 8'(i % 4));
      chk($sformatf("cyc1 lamps%0d", i), {5'd0, red_b, amber_b, green_b}, {5'd0, lamps(2'(i % 4))});
      step();
    end

`ifdef TRAFFIC_PED_REQ_EN
    // request during RED: GREEN shortened to the 2-cycle minimum, walk for following RED
    do_reset();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk_a($sformatf("ped5_%0d", i), exp5[i]);
      chk($sformatf("ped5 walk%0d", i), {7'd0, walk_a}, {7'd0, i >= 10 && i < 14});
      step();
    end
    // request at GREEN cycle 3 ends GREEN after cycle 4; next period without request
    do_reset();
    for (int i = 0; i < 31; i++) begin
      ped_req = i == 8;
      chk_a($sformatf("ped6_%0d", i), exp6[i]);
      chk($sformatf("ped6 walk%0d", i), {7'd0, walk_a}, {7'd0, i >= 13 && i < 17});
      step();
    end
    ped_req = 1'b0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
